seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial pattern detector: the next generation of the team's fixed "0110" detector. It accepts one bit per qualified clock and pulses `z` when the last `PAT_W` accepted bits equal a runtime-loadable pattern. Overlapping or non-overlapping detection is selected at runtime, and a saturating match counter is provided. It sits between a serial bit source and control logic that consumes match events.

## Interface
- `PAT_W`, default 4: pattern length in bits. Legal range is 2..32.
- `CNT_W`, default 8: width of the match counter.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset_n`  input  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `x`  input  1: serial data bit.
- `x_valid`  input  1: `x` is accepted on an edge only when this is 1.
- `cfg_load`  input  1: latch `cfg_pattern` and `cfg_overlap` into internal config registers.
- `cfg_pattern`  input  PAT_W: pattern. Bit `PAT_W-1` is the first bit received, bit 0 the last. "0110" is `4'b0110`.
- `cfg_overlap`  input  1: 1 = overlapping detection, 0 = non-overlapping.
- `cnt_clear`  input  1: zero the match counter.
- `z`  output  1: registered one-cycle match pulse.
- `match_count`  output  CNT_W: saturating count of matches.
- `primed`  output  1: at least `PAT_W` bits accepted since the last reset, load or non-overlap restart.

## Operation
- Internal state:
  - pattern register `pat`;
  - overlap register `ovl`;
  - history shift register `hist[PAT_W-1:0]`;
  - fill counter `fill`, width clog2(PAT_W+1), saturating at `PAT_W`;
  - `match_count`;
  - `z`.
- Reset (`reset_n`=0) values:
  - `pat` = 0, `ovl` = 1;
  - `hist` = 0, `fill` = 0;
  - `z` = 0, `match_count` = 0, `primed` = 0.
- Accept edge (`x_valid`=1, `cfg_load`=0):
  - next history is `nh = {hist[PAT_W-2:0], x}`.
  - A hit occurs when `fill >= PAT_W-1` and `nh == pat`.
- On an accept edge with a hit:
  - `z` <= 1.
  - `match_count` increments, saturating at all-ones.
  - If `ovl`=1: `hist` <= `nh`, `fill` <= `PAT_W`.
  - If `ovl`=0: `hist` <= 0, `fill` <= 0, so a new match needs `PAT_W` fresh bits.
- On an accept edge without a hit: `hist` <= `nh`, `fill` <= min(`fill`+1, `PAT_W`), `z` <= 0.
- No accept (`x_valid`=0): `hist` and `fill` hold, `z` <= 0.
- `cfg_load`=1:
  - `pat` <= `cfg_pattern`, `ovl` <= `cfg_overlap`.
  - `hist` <= 0, `fill` <= 0, `z` <= 0.
  - `x` is ignored that cycle even if `x_valid`=1.
  - `match_count` is unaffected.
- `cnt_clear`=1:
  - `match_count` <= 0, taking priority over an increment on the same edge.
  - Detection and `z` are unaffected; a hit on that edge still pulses `z` but is not counted.
- `primed` = (`fill` == `PAT_W`), combinational from `fill`.
- Priority, highest first: `reset_n` low, then `cfg_load`, then normal accept/hold.

## Timing
- Latency: `z` rises on the same edge that accepts the bit completing the pattern, and is visible for the following cycle. This is one cycle later than a combinational Mealy output.
- `z` is high for exactly one cycle per match.
- Back-to-back `z` is possible only when `ovl`=1 and the pattern overlaps itself by `PAT_W-1` bits (e.g. all ones).
- `match_count` updates on the same edge as `z`.
- `reset_n` asserted mid-stream clears all state on that edge.
  - A pattern completing on that edge is lost: no `z`, no count.
  - `pat` returns to 0, so software must reload the pattern.
- Gaps in `x_valid` of any length do not break a partial match.
- No combinational path from `x` to `z`.

## Test plan
- Overlap: load `0110`, `ovl`=1, stream 0,1,1,0,1,1,0 with `x_valid`=1 → `z` pulses after the 4th and 7th bits; `match_count`=2.
- Non-overlap: same stream, `ovl`=0 → `z` pulses after the 4th bit only; `match_count`=1. Then stream 0,1,1,0 → second pulse; count=2.
- Qualifier gaps: load `0110`, send 0,1 then 5 cycles `x_valid`=0, then 1,0 → one `z` pulse after the final bit; no pulses during the gap.
- Reset/reload mid-stream:
  - after 0,1,1 assert `reset_n`=0 for one cycle, reload `0110`, send 0 → no `z`; `primed`=0.
  - repeat with `cfg_load` instead of reset → same result, and `match_count` is retained.
- Saturation/clear: `CNT_W`=2, pattern `11`, `ovl`=1, stream eight 1s → seven `z` pulses; `match_count` sticks at 3. Then `cnt_clear` on a hit edge → `z`=1, count=0.
- Width: `PAT_W`=8, pattern `8'hA5`, random 500-bit stream → `z` and `match_count` match a software sliding-window model in both modes.

Source files
------------

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with runtime pattern, overlap mode and match counter
module seq_detector_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clear,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             primed
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat;
    logic              ovl;
    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  nh;
    logic [FILL_W-1:0] fill;
    logic              accept;
    logic              hit;

    assign nh     = {hist[PAT_W-2:0], x};
    assign accept = x_valid && !cfg_load;
    // fill guards against the zeroed history masquerading as real bits
    assign hit    = accept && (fill >= FILL_HIT) && (nh == pat);
    assign primed = (fill == FILL_MAX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pat  <= '0;
            ovl  <= 1'b1;
            hist <= '0;
            fill <= '0;
            z    <= 1'b0;
        end else if (cfg_load) begin
            pat  <= cfg_pattern;
            ovl  <= cfg_overlap;
            hist <= '0;
            fill <= '0;
            z    <= 1'b0;
        end else if (x_valid) begin
            z <= hit;
            if (hit && !ovl) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= nh;
                fill <= (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
            end
        end else begin
            z <= 1'b0;
        end
    end

    // clear outranks a same-edge hit; load leaves the count alone
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            match_count <= '0;
        end else if (cnt_clear) begin
            match_count <= '0;
        end else if (hit && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed and model-based checks for seq_detector_param
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       x;
    logic       x_valid;
    logic       cfg_load;
    logic       cfg_overlap;
    logic       cnt_clear;
    logic [3:0] pat4;
    logic [1:0] pat2;
    logic [7:0] pat8;

    logic       z_a, z_b, z_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;
    logic       primed_a, primed_b, primed_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .CNT_W(8)) u_a (
        .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid),
        .cfg_load(cfg_load), .cfg_pattern(pat4), .cfg_overlap(cfg_overlap),
        .cnt_clear(cnt_clear), .z(z_a), .match_count(cnt_a), .primed(primed_a)
    );

    seq_detector_param #(.PAT_W(2), .CNT_W(2)) u_b (
        .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid),
        .cfg_load(cfg_load), .cfg_pattern(pat2), .cfg_overlap(cfg_overlap),
        .cnt_clear(cnt_clear), .z(z_b), .match_count(cnt_b), .primed(primed_b)
    );

    seq_detector_param #(.PAT_W(8), .CNT_W(8)) u_c (
        .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid),
        .cfg_load(cfg_load), .cfg_pattern(pat8), .cfg_overlap(cfg_overlap),
        .cnt_clear(cnt_clear), .z(z_c), .match_count(cnt_c), .primed(primed_c)
    );

    typedef struct {
        logic       rst_n;
        logic       ld;
        logic [3:0] pat;
        logic       ovl;
        logic       clr;
        logic       v;
        logic       xb;
        logic       ez;
        logic [7:0] ecnt;
        logic       ep;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic rst_n, input logic ld, input logic [3:0] pat,
                                input logic ovl, input logic clr, input logic v, input logic xb,
                                input logic ez, input logic [7:0] ecnt, input logic ep);
        vec_t r;
        r.rst_n = rst_n; r.ld = ld; r.pat = pat; r.ovl = ovl; r.clr = clr;
        r.v = v; r.xb = xb; r.ez = ez; r.ecnt = ecnt; r.ep = ep;
        vt.push_back(r);
    endfunction

    // shorthand for a plain accepted bit under the current config
    function automatic void bit_in(input logic xb, input logic ez, input logic [7:0] ecnt, input logic ep);
        add(1, 0, 4'b0110, 1, 0, 1, xb, ez, ecnt, ep);
    endfunction

    function automatic void idle(input logic [7:0] ecnt, input logic ep);
        add(1, 0, 4'b0110, 1, 0, 0, 0, 0, ecnt, ep);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input logic ovl_m);
        bit         q[$];
        logic [7:0] w;
        logic       ez;
        logic [7:0] ecnt;
        pat8        = 8'hA5;
        cfg_overlap = ovl_m;
        cfg_load    = 1'b1;
        cnt_clear   = 1'b1;
        x_valid     = 1'b0;
        tick();
        cfg_load  = 1'b0;
        cnt_clear = 1'b0;
        ecnt = 8'd0;
        for (int i = 0; i < 500; i++) begin
            x_valid = ($urandom_range(0, 3) != 0);
            x       = 1'($urandom);
            ez = 1'b0;
            if (x_valid) begin
                q.push_back(x);
                if (q.size() > 8) void'(q.pop_front());
                if (q.size() == 8) begin
                    for (int k = 0; k < 8; k++) w[7-k] = q[k];
                    if (w == 8'hA5) begin
                        ez = 1'b1;
                        if (ecnt != 8'hFF) ecnt = ecnt + 8'd1;
                        if (!ovl_m) q.delete();
                    end
                end
            end
            tick();
            check($sformatf("rnd%0d_%0d_z", ovl_m, i), 32'(z_c), 32'(ez));
            check($sformatf("rnd%0d_%0d_cnt", ovl_m, i), 32'(cnt_c), 32'(ecnt));
            check($sformatf("rnd%0d_%0d_primed", ovl_m, i), 32'(primed_c), 32'(q.size() == 8));
        end
        x_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
        cfg_overlap = 1'b1; cnt_clear = 1'b0;
        pat4 = 4'b0; pat2 = 2'b0; pat8 = 8'b0;

        // reset, including a valid bit that must be ignored
        add(0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 4'b0000, 1, 0, 1, 1, 0, 0, 0);
        // reset pattern is zero with overlap on: four zeros match
        bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(0, 1, 1, 1);
        // overlap: 0110110
        add(1, 1, 4'b0110, 1, 1, 0, 0, 0, 0, 0);
        bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 1);
        bit_in(1, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(0, 1, 2, 1);
        // non-overlap: 0110110 then 0110
        add(1, 1, 4'b0110, 0, 1, 0, 0, 0, 0, 0);
        bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 0);
        bit_in(1, 0, 1, 0); bit_in(1, 0, 1, 0); bit_in(0, 0, 1, 0);
        bit_in(0, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(0, 1, 2, 0);
        // qualifier gap in the middle of a match
        add(1, 1, 4'b0110, 1, 1, 0, 0, 0, 0, 0);
        bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) idle(0, 0);
        bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 1); idle(1, 1);
        // reset mid-stream loses the completing bit
        add(1, 1, 4'b0110, 1, 0, 0, 0, 0, 1, 0);
        bit_in(0, 0, 1, 0); bit_in(1, 0, 1, 0); bit_in(1, 0, 1, 0);
        add(0, 0, 4'b0110, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 4'b0110, 1, 0, 0, 0, 0, 0, 0);
        bit_in(0, 0, 0, 0);
        // cfg_load mid-stream ignores x and keeps the count
        bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 1, 1, 1);
        bit_in(0, 0, 1, 1); bit_in(1, 0, 1, 1); bit_in(1, 0, 1, 1);
        add(1, 1, 4'b0110, 1, 0, 1, 0, 0, 1, 0);
        bit_in(0, 0, 1, 0);

        for (int i = 0; i < vt.size(); i++) begin
            reset_n     = vt[i].rst_n;
            cfg_load    = vt[i].ld;
            pat4        = vt[i].pat;
            cfg_overlap = vt[i].ovl;
            cnt_clear   = vt[i].clr;
            x_valid     = vt[i].v;
            x           = vt[i].xb;
            tick();
            check($sformatf("vec%0d_z", i), 32'(z_a), 32'(vt[i].ez));
            check($sformatf("vec%0d_cnt", i), 32'(cnt_a), 32'(vt[i].ecnt));
            check($sformatf("vec%0d_primed", i), 32'(primed_a), 32'(vt[i].ep));
        end

        // saturation and clear-on-hit with a 2-bit pattern and 2-bit counter
        reset_n = 1'b1; pat2 = 2'b11; cfg_overlap = 1'b1;
        cfg_load = 1'b1; cnt_clear = 1'b1; x_valid = 1'b0;
        tick();
        check("sat_load_cnt", 32'(cnt_b), 32'd0);
        check("sat_load_primed", 32'(primed_b), 32'd0);
        cfg_load = 1'b0; cnt_clear = 1'b0; x_valid = 1'b1; x = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("sat%0d_z", i), 32'(z_b), 32'(i >= 1));
            check($sformatf("sat%0d_cnt", i), 32'(cnt_b), 32'((i > 3) ? 3 : i));
        end
        cnt_clear = 1'b1;
        tick();
        check("clr_hit_z", 32'(z_b), 32'd1);
        check("clr_hit_cnt", 32'(cnt_b), 32'd0);
        cnt_clear = 1'b0;
        tick();
        check("after_clr_z", 32'(z_b), 32'd1);
        check("after_clr_cnt", 32'(cnt_b), 32'd1);

        run_random(1'b1);
        run_random(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
